// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared op codes, FSM encoding and geometry for the data cache
package cache_pkg;

  localparam int LINES = 8;
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - 4 - IDX_W;

  localparam logic [3:0] RW_LB  = 4'b1000;
  localparam logic [3:0] RW_LH  = 4'b1001;
  localparam logic [3:0] RW_LW  = 4'b1010;
  localparam logic [3:0] RW_SB  = 4'b1011;
  localparam logic [3:0] RW_LBU = 4'b1100;
  localparam logic [3:0] RW_LHU = 4'b1101;
  localparam logic [3:0] RW_SH  = 4'b1110;
  localparam logic [3:0] RW_SW  = 4'b1111;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;
  localparam logic [1:0] ST_UPDATE    = 2'd3;

endpackage

// File: rtl/data_cache_controller_if.sv
// rtl/data_cache_controller_if.sv - 128-bit block handshake between cache and main memory
interface data_cache_controller_if;

  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  modport master (
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT
  );

  modport slave (
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT
  );

endinterface

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - load extraction/extension and store byte-lane merge for one line
module load_store_align
  import cache_pkg::*;
(
  input  logic [3:0]   rw,
  input  logic [3:0]   offset,
  input  logic [127:0] line,
  input  logic [31:0]  store_data,
  output logic [31:0]  load_data,
  output logic [127:0] store_line,
  output logic [15:0]  lane_mask
);

  logic [7:0]   sel_byte;
  logic [15:0]  sel_half;
  logic [31:0]  sel_word;
  logic [127:0] lane_data;

  // Low offset bits below the access size are dropped, so misaligned accesses round down.
  assign sel_byte = line[{offset, 3'b000} +: 8];
  assign sel_half = line[{offset[3:1], 4'b0000} +: 16];
  assign sel_word = line[{offset[3:2], 5'b00000} +: 32];

  always_comb begin
    load_data = '0;
    lane_mask = '0;
    lane_data = '0;
    case (rw)
      RW_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      RW_LBU:  load_data = {24'd0, sel_byte};
      RW_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      RW_LHU:  load_data = {16'd0, sel_half};
      RW_LW:   load_data = sel_word;
      RW_SB: begin
        lane_mask = 16'h0001 << offset;
        lane_data = {16{store_data[7:0]}};
      end
      RW_SH: begin
        lane_mask = 16'h0003 << {offset[3:1], 1'b0};
        lane_data = {8{store_data[15:0]}};
      end
      RW_SW: begin
        lane_mask = 16'h000F << {offset[3:2], 2'b00};
        lane_data = {4{store_data}};
      end
      default: ;
    endcase
  end

  always_comb begin
    store_line = line;
    for (int i = 0; i < 16; i++) begin
      if (lane_mask[i]) store_line[i*8 +: 8] = lane_data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/data_cache_controller.sv
// rtl/data_cache_controller.sv - direct-mapped write-back write-allocate data cache with refill FSM
module data_cache_controller
  import cache_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [3:0]             READ_WRITE,
  input  logic [31:0]            ADDRESS,
  input  logic [31:0]            DATA_IN,
  output logic [31:0]            DATA_OUT,
  output logic                   BUSYWAIT,
  data_cache_controller_if.master mem
);

  logic [127:0]     data_arr [LINES];
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [127:0]     fill_buf;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             access;
  logic             hit;
  logic             idle_hit;
  logic [31:0]      load_data;
  logic [127:0]     store_line;
  logic [15:0]      lane_mask;

  assign idx      = ADDRESS[4 +: IDX_W];
  assign tag      = ADDRESS[31 -: TAG_W];
  assign access   = READ_WRITE[3];
  assign hit      = valid[idx] && (tag_arr[idx] == tag);
  assign idle_hit = access && hit && (state == ST_IDLE);

  load_store_align u_align (
    .rw         (READ_WRITE),
    .offset     (ADDRESS[3:0]),
    .line       (data_arr[idx]),
    .store_data (DATA_IN),
    .load_data  (load_data),
    .store_line (store_line),
    .lane_mask  (lane_mask)
  );

  assign DATA_OUT = idle_hit ? load_data : 32'd0;
  assign BUSYWAIT = access && !idle_hit;

  assign mem.MEM_READ      = (state == ST_ALLOCATE);
  assign mem.MEM_WRITE     = (state == ST_WRITEBACK);
  assign mem.MEM_ADDRESS   = (state == ST_WRITEBACK) ? {tag_arr[idx], idx} : ADDRESS[31:4];
  assign mem.MEM_WRITEDATA = data_arr[idx];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (access && !hit)
          state_nxt = (valid[idx] && dirty[idx]) ? ST_WRITEBACK : ST_ALLOCATE;
      end
      ST_WRITEBACK: if (!mem.MEM_BUSYWAIT) state_nxt = ST_ALLOCATE;
      ST_ALLOCATE:  if (!mem.MEM_BUSYWAIT) state_nxt = ST_UPDATE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Data and tag arrays are deliberately left untouched by reset; valid gates them.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ALLOCATE && !mem.MEM_BUSYWAIT)
        fill_buf <= mem.MEM_READDATA;
      if (state == ST_UPDATE) begin
        data_arr[idx] <= fill_buf;
        tag_arr[idx]  <= tag;
        valid[idx]    <= 1'b1;
        dirty[idx]    <= 1'b0;
      end else if (idle_hit && (|lane_mask)) begin
        data_arr[idx] <= store_line;
        dirty[idx]    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// tb/tb_data_cache_controller.sv - directed plus randomized bench against a byte-level cache model
module tb_data_cache_controller;
  import cache_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  READ_WRITE = 4'd0;
  logic [31:0] ADDRESS = 32'd0;
  logic [31:0] DATA_IN = 32'd0;
  logic [31:0] DATA_OUT;
  logic        BUSYWAIT;

  data_cache_controller_if mem_bus();

  data_cache_controller dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .READ_WRITE (READ_WRITE),
    .ADDRESS    (ADDRESS),
    .DATA_IN    (DATA_IN),
    .DATA_OUT   (DATA_OUT),
    .BUSYWAIT   (BUSYWAIT),
    .mem        (mem_bus)
  );

  always #5 CLK = ~CLK;

  logic [127:0] bench_mem [logic [27:0]];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [24:0]  m_tag   [8];
  logic [7:0]   m_line  [8][16];
  int           n_vec = 0;
  int           n_err = 0;
  int           lat_force = -1;

  function automatic logic [127:0] mem_rd(logic [27:0] a);
    if (bench_mem.exists(a)) return bench_mem[a];
    return {~{4'h0, a}, {4'h0, a} ^ 32'hA5C35A3C, {a, 4'h7}, 32'h0BADF00D ^ {4'h0, a}};
  endfunction

  function automatic logic [127:0] pack_line(int idx);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_line[idx][i];
    return v;
  endfunction

  function automatic void fill_line(int idx, logic [127:0] v);
    for (int i = 0; i < 16; i++) m_line[idx][i] = v[i*8 +: 8];
  endfunction

  function automatic logic [31:0] exp_load(logic [3:0] rw, int idx, int off);
    int h;
    int w;
    logic [31:0] bv;
    logic [31:0] hv;
    h  = off - (off % 2);
    w  = off - (off % 4);
    bv = 32'(m_line[idx][off]);
    hv = 32'(m_line[idx][h]) + 32'(m_line[idx][h+1]) * 256;
    case (rw)
      RW_LB:  return (bv > 127) ? (bv | 32'hFFFFFF00) : bv;
      RW_LBU: return bv;
      RW_LH:  return (hv > 32767) ? (hv | 32'hFFFF0000) : hv;
      RW_LHU: return hv;
      RW_LW:  return {m_line[idx][w+3], m_line[idx][w+2], m_line[idx][w+1], m_line[idx][w]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_store(logic [3:0] rw, int idx, int off, logic [31:0] d);
    int h;
    int w;
    h = off - (off % 2);
    w = off - (off % 4);
    case (rw)
      RW_SB: m_line[idx][off] = d[7:0];
      RW_SH: begin
        m_line[idx][h]   = d[7:0];
        m_line[idx][h+1] = d[15:8];
      end
      RW_SW: for (int k = 0; k < 4; k++) m_line[idx][w+k] = d[8*k +: 8];
      default: ;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: each new request is held busy for a random (or forced) number of cycles.
  initial begin : mem_model
    int cnt;
    bit active;
    cnt = 0;
    active = 0;
    mem_bus.MEM_BUSYWAIT = 1'b0;
    mem_bus.MEM_READDATA = '0;
    forever begin
      @(negedge CLK);
      if (!(mem_bus.MEM_READ || mem_bus.MEM_WRITE)) begin
        active = 0;
        mem_bus.MEM_BUSYWAIT = 1'b0;
      end else begin
        if (!active) begin
          active = 1;
          cnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
        end
        if (cnt > 0) begin
          cnt--;
          mem_bus.MEM_BUSYWAIT = 1'b1;
        end else begin
          mem_bus.MEM_BUSYWAIT = 1'b0;
          if (mem_bus.MEM_READ) mem_bus.MEM_READDATA = mem_rd(mem_bus.MEM_ADDRESS);
          active = 0;
        end
      end
    end
  end

  task automatic do_access(input logic [3:0] rw, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] dout);
    int idx;
    int off;
    int cyc;
    logic [24:0] tg;
    logic [127:0] vline;
    bit miss, wb, saw_wb, saw_rd, both;
    idx = int'(a[6:4]);
    off = int'(a[3:0]);
    tg  = a[31:7];
    READ_WRITE = rw;
    ADDRESS    = a;
    DATA_IN    = d;
    #1;
    miss = !(m_valid[idx] && m_tag[idx] == tg);
    chk("busy_on_access", BUSYWAIT, miss);
    if (miss) begin
      wb = m_dirty[idx];
      vline = pack_line(idx);
      saw_wb = 0;
      saw_rd = 0;
      both = 0;
      cyc = 0;
      while (BUSYWAIT === 1'b1 && cyc < 80) begin
        if (mem_bus.MEM_READ && mem_bus.MEM_WRITE) both = 1;
        if (mem_bus.MEM_WRITE && !saw_wb) begin
          saw_wb = 1;
          chk("wb_addr", mem_bus.MEM_ADDRESS, {m_tag[idx], a[6:4]});
          chk("wb_data", mem_bus.MEM_WRITEDATA, vline);
        end
        if (mem_bus.MEM_READ && !saw_rd) begin
          saw_rd = 1;
          chk("wb_before_rd", saw_wb, wb);
          chk("rd_addr", mem_bus.MEM_ADDRESS, a[31:4]);
        end
        @(posedge CLK);
        #1;
        cyc++;
      end
      chk("miss_in_time", cyc < 80, 1'b1);
      chk("wb_seen", saw_wb, wb);
      chk("rd_seen", saw_rd, 1'b1);
      chk("rd_wr_excl", both, 1'b0);
      if (wb) bench_mem[{m_tag[idx], a[6:4]}] = vline;
      fill_line(idx, mem_rd(a[31:4]));
      m_tag[idx]   = tg;
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
    end else begin
      chk("hit_no_mem", {mem_bus.MEM_READ, mem_bus.MEM_WRITE}, 2'b00);
    end
    chk("busy_after", BUSYWAIT, 1'b0);
    dout = DATA_OUT;
    if (rw inside {RW_SB, RW_SH, RW_SW}) begin
      model_store(rw, idx, off, d);
      m_dirty[idx] = 1;
    end else begin
      chk("load_data", DATA_OUT, exp_load(rw, idx, off));
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      READ_WRITE = {1'b0, 3'($urandom_range(0, 7))};
      ADDRESS    = $urandom;
      DATA_IN    = $urandom;
      #1;
      chk("idle_busy", BUSYWAIT, 1'b0);
      chk("idle_dout", DATA_OUT, 32'd0);
      chk("idle_mem", {mem_bus.MEM_READ, mem_bus.MEM_WRITE}, 2'b00);
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin : stim
    logic [31:0] r;
    logic [3:0]  rw;
    logic [31:0] a;
    int          cyc;

    bench_mem[28'h4] = {32'hDDCCBBAA, 32'h88776655, 32'h0F0E0D0C, 32'h44332211};

    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy_idle", BUSYWAIT, 1'b0);
    chk("rst_dout", DATA_OUT, 32'd0);
    chk("rst_mem", {mem_bus.MEM_READ, mem_bus.MEM_WRITE}, 2'b00);
    READ_WRITE = RW_LW;
    ADDRESS = 32'h40;
    #1;
    chk("rst_busy_access", BUSYWAIT, 1'b1);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    lat_force = 3;
    do_access(RW_LW, 32'h40, 32'd0, r);
    chk("cold_lw", r, 32'h44332211);
    lat_force = -1;

    do_access(RW_LB, 32'h43, 32'd0, r);   chk("lb_43", r, 32'h00000044);
    do_access(RW_LB, 32'h4C, 32'd0, r);   chk("lb_4c", r, 32'hFFFFFFAA);
    do_access(RW_LBU, 32'h4C, 32'd0, r);  chk("lbu_4c", r, 32'h000000AA);
    do_access(RW_LH, 32'h4E, 32'd0, r);   chk("lh_4e", r, 32'hFFFFDDCC);
    do_access(RW_LHU, 32'h4E, 32'd0, r);  chk("lhu_4e", r, 32'h0000DDCC);

    do_access(RW_SB, 32'h41, 32'h123456EF, r);
    do_access(RW_LW, 32'h40, 32'd0, r);   chk("lw_after_sb", r, 32'h4433EF11);

    do_access(RW_SW, 32'hC0, 32'hCAFEF00D, r);
    do_access(RW_LW, 32'hC0, 32'd0, r);   chk("lw_c0", r, 32'hCAFEF00D);
    do_access(RW_LW, 32'h40, 32'd0, r);   chk("lw_40_refetch", r, 32'h4433EF11);

    idle_cycles(10);
    do_access(RW_LB, 32'h43, 32'd0, r);   chk("lb_after_idle", r, 32'h00000044);

    lat_force = 20;
    READ_WRITE = RW_LW;
    ADDRESS = 32'h00000150;
    DATA_IN = 32'd0;
    cyc = 0;
    while (mem_bus.MEM_READ !== 1'b1 && cyc < 40) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    chk("alloc_reached", mem_bus.MEM_READ, 1'b1);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_mid_mem", {mem_bus.MEM_READ, mem_bus.MEM_WRITE}, 2'b00);
    chk("rst_mid_busy", BUSYWAIT, 1'b1);
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    RESET = 1'b0;
    lat_force = -1;
    do_access(RW_LW, 32'h40, 32'd0, r);   chk("post_rst_lw", r, 32'h4433EF11);

    for (int i = 0; i < 400; i++) begin
      rw = {1'b1, 3'($urandom_range(0, 7))};
      a = $urandom;
      a[31:7] = 25'($urandom_range(0, 3));
      do_access(rw, a, $urandom, r);
      if ($urandom_range(0, 7) == 0) idle_cycles(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
